nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
Control FSM that runs one MNIST inference on the shared MAC datapath inside top_nn. It streams the input layer into the hidden layer and the hidden layer into the output layer, one neuron at a time. It handles memory address generation, MAC enable/clear, ReLU/requantisation write-back to the hidden buffer, and a running argmax. Result is presented as digit_out with a one-cycle valid_out pulse.

Parameters:
N_IN, 784, input activations per image
N_HID, 64, hidden neurons
N_OUT, 10, output neurons (digit_out must hold N_OUT-1)
ACC_W, 32, signed MAC accumulator width
ACT_W, 8, unsigned hidden activation width
SHIFT, 8, requantisation right-shift applied to the hidden accumulator

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin inference; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE inclusive
valid_out  out  1  one-cycle result pulse
digit_out  out  4  argmax index; held until the next accepted start
w_addr  out  clog2(N_IN*N_HID+N_HID*N_OUT)  weight ROM address
w_rd_en  out  1  weight read strobe
x_addr  out  clog2(N_IN)  input image RAM address
x_rd_en  out  1  image read strobe
h_rd_addr  out  clog2(N_HID)  hidden buffer read address
h_rd_en  out  1  hidden read strobe
mac_sel  out  1  operand mux: 0 = image, 1 = hidden
mac_clr  out  1  synchronous accumulator clear
mac_en  out  1  accumulate enable
mac_acc  in  ACC_W  signed accumulator value (registered in datapath)
h_wr_en  out  1  hidden buffer write strobe
h_wr_addr  out  clog2(N_HID)  hidden write address
h_wr_data  out  ACT_W  ReLU/requantised activation

Behaviour:
- Memories have 1-cycle read latency. MAC updates at the edge where mac_en=1.
- States: IDLE, L1_RUN, L1_DRAIN, L1_WB, L2_RUN, L2_DRAIN, L2_CMP, DONE.
- IDLE: mac_clr=1; all strobes 0. When start=1, go to L1_RUN and clear the counters (k, neuron, w_addr = 0).
- x_RUN: one operand is issued per cycle: w_rd_en=1 plus x_rd_en (L1) or h_rd_en (L2). Operand address = k. w_addr increments every RUN cycle and is never reset between neurons or layers, so the weight layout is contiguous: L1 weights at j*N_IN+k, L2 weights at N_IN*N_HID + o*N_HID + h. When k = last index, go to DRAIN.
- mac_en = any read strobe delayed one cycle. It therefore covers RUN cycles 2..N plus DRAIN.
- mac_sel = 0 throughout L1 and 1 throughout L2, including DRAIN.
- L1_WB (1 cycle): h_wr_en=1, h_wr_addr=j.
  - h_wr_data = 0 if mac_acc<0.
  - Otherwise h_wr_data = min(mac_acc>>>SHIFT, 2^ACT_W-1).
  - mac_clr=1 in the same cycle.
  - Next state: L1_RUN if j<N_HID-1, else L2_RUN.
- L2_CMP (1 cycle): signed compare of mac_acc against best.
  - o==0 loads best unconditionally.
  - For o>0, update best and best_idx only on strictly greater, so ties keep the lower index.
  - mac_clr=1. Next state: L2_RUN if o<N_OUT-1, else DONE.
- DONE (1 cycle): digit_out <= best_idx, valid_out=1, then IDLE.
- Cycles per neuron = fan-in+2. Latency: valid_out is high in cycle N_HID*(N_IN+2)+N_OUT*(N_HID+2)+1 after the start-sampling edge (50965 at defaults).
- start is ignored outside IDLE.
- reset=0 at any time: state IDLE; busy=0, valid_out=0, digit_out=0, all strobes/addresses=0, mac_clr=1. No partial result is ever flagged valid.

Decomposition:
- Shared package nn_pkg holds:
  - state enum
  - N_IN/N_HID/N_OUT/ACC_W/ACT_W/SHIFT defaults
  - derived address widths
  - L2 weight base offset constant N_IN*N_HID
- Natural sub-module: nn_argmax_tracker, the best/best_idx register with compare and tie rule, reused by later classifier heads.
- ReLU/saturate stays inline.

Test Plan:
Bench uses N_IN=4, N_HID=3, N_OUT=2 with behavioural ROM/RAM/MAC models; latency is 3*6+2*5+1 = 29.
1. Hold reset=0 for 3 cycles -> busy=0, valid_out=0, digit_out=0, mac_clr=1, all strobes 0. Release -> stays IDLE.
2. Start with weights all 1, image {1,2,3,4}, SHIFT=0 -> hidden {10,10,10}; outputs tie at 30 -> digit_out=0. valid_out high only in cycle 29. w_addr sequence is 0..11 then 12..17.
3. Hidden accumulators -5, 0x10000, 0x0300 with SHIFT=8 -> h_wr_data 0, 255, 3 at h_wr_addr 0, 1, 2.
4. Outputs {-7,-3} -> digit_out=1. Outputs {5,5} -> 0. Outputs {6,5} -> 0.
5. Pulse start again at cycles 5 and 20 of a run -> ignored, single valid_out. A second start issued the cycle after DONE -> a full 29-cycle run with mac cleared.
6. reset=0 asynchronously mid-L1_RUN (cycle 8) -> outputs take reset values before the next edge and no valid_out. Restart -> correct digit_out.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants, helpers and state encoding for the MNIST layer sequencer.
package nn_pkg;

   localparam int N_IN_DEF  = 784;
   localparam int N_HID_DEF = 64;
   localparam int N_OUT_DEF = 10;
   localparam int ACC_W_DEF = 32;
   localparam int ACT_W_DEF = 8;
   localparam int SHIFT_DEF = 8;

   // Address width for a memory of n words, never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int W_AW_DEF  = addr_w(N_IN_DEF * N_HID_DEF + N_HID_DEF * N_OUT_DEF);
   localparam int X_AW_DEF  = addr_w(N_IN_DEF);
   localparam int H_AW_DEF  = addr_w(N_HID_DEF);
   localparam int L2_W_BASE = N_IN_DEF * N_HID_DEF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_RUN,
      S_L1_DRAIN,
      S_L1_WB,
      S_L2_RUN,
      S_L2_DRAIN,
      S_L2_CMP,
      S_DONE
   } state_t;

endpackage

// File: rtl/nn_argmax_tracker.sv
// Running argmax register: first candidate loads unconditionally, later ones
// replace it only when strictly greater (signed), so ties keep the lower index.
module nn_argmax_tracker #(
   parameter int VAL_W = 32,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             first,
   input  logic [VAL_W-1:0] value,
   input  logic [IDX_W-1:0] idx,
   output logic [IDX_W-1:0] best_idx,
   output logic [IDX_W-1:0] idx_nxt
);

   logic [VAL_W-1:0] best;
   logic             take;

   assign take    = en && (first || ($signed(value) > $signed(best)));
   assign idx_nxt = take ? idx : best_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         best     <= '0;
         best_idx <= '0;
      end else if (take) begin
         best     <= value;
         best_idx <= idx;
      end
   end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Two-layer inference sequencer driving a shared MAC: address generation,
// MAC control, ReLU/requantised hidden write-back and running argmax.
module nn_layer_sequencer
   import nn_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int N_HID = N_HID_DEF,
   parameter int N_OUT = N_OUT_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int ACT_W = ACT_W_DEF,
   parameter int SHIFT = SHIFT_DEF,
   localparam int W_AW = addr_w(N_IN * N_HID + N_HID * N_OUT),
   localparam int X_AW = addr_w(N_IN),
   localparam int H_AW = addr_w(N_HID)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             valid_out,
   output logic [3:0]       digit_out,
   output logic [W_AW-1:0]  w_addr,
   output logic             w_rd_en,
   output logic [X_AW-1:0]  x_addr,
   output logic             x_rd_en,
   output logic [H_AW-1:0]  h_rd_addr,
   output logic             h_rd_en,
   output logic             mac_sel,
   output logic             mac_clr,
   output logic             mac_en,
   input  logic [ACC_W-1:0] mac_acc,
   output logic             h_wr_en,
   output logic [H_AW-1:0]  h_wr_addr,
   output logic [ACT_W-1:0] h_wr_data
);

   localparam int KW = addr_w((N_IN > N_HID) ? N_IN : N_HID);
   localparam int NW = addr_w((N_HID > N_OUT) ? N_HID : N_OUT);
   localparam logic [ACC_W-1:0] ACT_MAX = ACC_W'((64'd1 << ACT_W) - 64'd1);

   state_t           state, state_nxt;
   logic [KW-1:0]    k;
   logic [NW-1:0]    n;
   logic [W_AW-1:0]  w_cnt;
   logic             rd_d;
   logic             run, k_last;
   logic [3:0]       idx_nxt;
   logic [3:0]       best_idx;
   logic [ACC_W-1:0] acc_shr;

   assign run    = (state == S_L1_RUN) || (state == S_L2_RUN);
   assign k_last = (state == S_L1_RUN) ? (k == KW'(N_IN - 1)) : (k == KW'(N_HID - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = S_L1_RUN;
         S_L1_RUN:   if (k_last) state_nxt = S_L1_DRAIN;
         S_L1_DRAIN: state_nxt = S_L1_WB;
         S_L1_WB:    state_nxt = (n == NW'(N_HID - 1)) ? S_L2_RUN : S_L1_RUN;
         S_L2_RUN:   if (k_last) state_nxt = S_L2_DRAIN;
         S_L2_DRAIN: state_nxt = S_L2_CMP;
         S_L2_CMP:   state_nxt = (n == NW'(N_OUT - 1)) ? S_DONE : S_L2_RUN;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // w_cnt is never rewound between neurons or layers: the weight ROM is laid
   // out contiguously, L2 weights starting right after the last L1 weight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k         <= '0;
         n         <= '0;
         w_cnt     <= '0;
         rd_d      <= 1'b0;
         digit_out <= '0;
      end else begin
         rd_d <= w_rd_en;
         case (state)
            S_IDLE: if (start) begin
               k     <= '0;
               n     <= '0;
               w_cnt <= '0;
            end
            S_L1_RUN, S_L2_RUN: begin
               w_cnt <= w_cnt + W_AW'(1);
               k     <= k_last ? '0 : k + KW'(1);
            end
            S_L1_WB:  n <= (n == NW'(N_HID - 1)) ? '0 : n + NW'(1);
            S_L2_CMP: begin
               n <= n + NW'(1);
               if (n == NW'(N_OUT - 1)) digit_out <= idx_nxt;
            end
            default: ;
         endcase
      end
   end

   nn_argmax_tracker #(.VAL_W(ACC_W), .IDX_W(4)) u_argmax (
      .clk      (clk),
      .reset    (reset),
      .en       (state == S_L2_CMP),
      .first    (n == '0),
      .value    (mac_acc),
      .idx      (4'(n)),
      .best_idx (best_idx),
      .idx_nxt  (idx_nxt)
   );

   assign busy      = (state != S_IDLE);
   assign valid_out = (state == S_DONE);
   assign w_rd_en   = run;
   assign w_addr    = w_cnt;
   assign x_rd_en   = (state == S_L1_RUN);
   assign h_rd_en   = (state == S_L2_RUN);
   assign x_addr    = x_rd_en ? k[X_AW-1:0] : '0;
   assign h_rd_addr = h_rd_en ? k[H_AW-1:0] : '0;
   assign mac_en    = rd_d;
   assign mac_sel   = (state == S_L2_RUN) || (state == S_L2_DRAIN) || (state == S_L2_CMP);
   assign mac_clr   = (state == S_IDLE) || (state == S_L1_WB) || (state == S_L2_CMP);
   assign h_wr_en   = (state == S_L1_WB);
   assign h_wr_addr = h_wr_en ? n[H_AW-1:0] : '0;

   assign acc_shr = ACC_W'($signed(mac_acc) >>> SHIFT);

   // ReLU then saturate to the unsigned activation range.
   always_comb begin
      h_wr_data = '0;
      if (h_wr_en && !mac_acc[ACC_W-1])
         h_wr_data = (acc_shr > ACT_MAX) ? ACT_MAX[ACT_W-1:0] : acc_shr[ACT_W-1:0];
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench: two sequencers (SHIFT 0 and 8) sharing weight ROM / image RAM models,
// each with its own hidden buffer and MAC model.
module tb_nn_layer_sequencer;

   localparam int N_IN = 4, N_HID = 3, N_OUT = 2, N_W = 18;
   localparam int WAW = 5, XAW = 2, HAW = 2;
   localparam int NV = 7;

   typedef struct packed {
      logic [N_W-1:0][31:0]  w;
      logic [N_IN-1:0][31:0] x;
      logic [N_HID-1:0][7:0] h0;
      logic [N_HID-1:0][7:0] h8;
      int                    d0;
      int                    d8;
   } vec_t;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   always #5 clk = ~clk;

   int wrom [N_W];
   int xram [N_IN];

   logic           busy [2], valid_out [2], w_rd_en [2], x_rd_en [2], h_rd_en [2];
   logic           mac_sel [2], mac_clr [2], mac_en [2], h_wr_en [2];
   logic [3:0]     digit_out [2];
   logic [WAW-1:0] w_addr [2];
   logic [XAW-1:0] x_addr [2];
   logic [HAW-1:0] h_rd_addr [2], h_wr_addr [2];
   logic [7:0]     h_wr_data [2];
   logic [31:0]    mac_acc [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      int w_q = 0, x_q = 0, h_q = 0, acc = 0;
      int hram [N_HID];
      always_ff @(posedge clk) begin
         if (w_rd_en[g]) w_q <= wrom[w_addr[g]];
         if (x_rd_en[g]) x_q <= xram[x_addr[g]];
         if (h_rd_en[g]) h_q <= hram[h_rd_addr[g]];
         if (h_wr_en[g]) hram[h_wr_addr[g]] <= int'(h_wr_data[g]);
         if (mac_clr[g])     acc <= 0;
         else if (mac_en[g]) acc <= acc + w_q * (mac_sel[g] ? h_q : x_q);
      end
      assign mac_acc[g] = acc;

      nn_layer_sequencer #(
         .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .ACC_W(32), .ACT_W(8), .SHIFT(g * 8)
      ) u_dut (
         .clk(clk), .reset(reset), .start(start), .busy(busy[g]), .valid_out(valid_out[g]),
         .digit_out(digit_out[g]), .w_addr(w_addr[g]), .w_rd_en(w_rd_en[g]),
         .x_addr(x_addr[g]), .x_rd_en(x_rd_en[g]), .h_rd_addr(h_rd_addr[g]),
         .h_rd_en(h_rd_en[g]), .mac_sel(mac_sel[g]), .mac_clr(mac_clr[g]), .mac_en(mac_en[g]),
         .mac_acc(mac_acc[g]), .h_wr_en(h_wr_en[g]), .h_wr_addr(h_wr_addr[g]),
         .h_wr_data(h_wr_data[g])
      );
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Cycle c counts from 1 = first cycle after the edge that accepts start.
   function automatic bit l1_strobe(input int c);
      return (c >= 1) && (c <= 18) && (((c - 1) % 6) < 4);
   endfunction
   function automatic bit l2_strobe(input int c);
      return (c >= 19) && (c <= 28) && (((c - 19) % 5) < 3);
   endfunction
   function automatic int exp_waddr(input int c);
      if (l1_strobe(c)) return 4 * ((c - 1) / 6) + (c - 1) % 6;
      return 12 + 3 * ((c - 19) / 5) + (c - 19) % 5;
   endfunction
   function automatic int exp_k(input int c);
      return l1_strobe(c) ? (c - 1) % 6 : (c - 19) % 5;
   endfunction

   task automatic check_reset_outputs(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk({tag, " busy"},      int'(busy[g]), 0);
         chk({tag, " valid"},     int'(valid_out[g]), 0);
         chk({tag, " digit"},     int'(digit_out[g]), 0);
         chk({tag, " mac_clr"},   int'(mac_clr[g]), 1);
         chk({tag, " mac_en"},    int'(mac_en[g]), 0);
         chk({tag, " w_rd_en"},   int'(w_rd_en[g]), 0);
         chk({tag, " x_rd_en"},   int'(x_rd_en[g]), 0);
         chk({tag, " h_rd_en"},   int'(h_rd_en[g]), 0);
         chk({tag, " h_wr_en"},   int'(h_wr_en[g]), 0);
         chk({tag, " w_addr"},    int'(w_addr[g]), 0);
         chk({tag, " x_addr"},    int'(x_addr[g]), 0);
         chk({tag, " h_rd_addr"}, int'(h_rd_addr[g]), 0);
         chk({tag, " h_wr_addr"}, int'(h_wr_addr[g]), 0);
         chk({tag, " h_wr_data"}, int'(h_wr_data[g]), 0);
      end
   endtask

   task automatic check_cycle(input int c, input vec_t v);
      string s;
      bit    wb;
      int    j;
      s  = $sformatf("c%0d", c);
      wb = (c <= 18) && (c % 6 == 0);
      j  = c / 6 - 1;
      chk({"busy ", s},    int'(busy[0]), int'(c <= 29));
      chk({"valid ", s},   int'(valid_out[0]), int'(c == 29));
      chk({"w_rd_en ", s}, int'(w_rd_en[0]), int'(l1_strobe(c) || l2_strobe(c)));
      chk({"x_rd_en ", s}, int'(x_rd_en[0]), int'(l1_strobe(c)));
      chk({"h_rd_en ", s}, int'(h_rd_en[0]), int'(l2_strobe(c)));
      if (l1_strobe(c) || l2_strobe(c)) chk({"w_addr ", s}, int'(w_addr[0]), exp_waddr(c));
      if (l1_strobe(c)) chk({"x_addr ", s}, int'(x_addr[0]), exp_k(c));
      if (l2_strobe(c)) chk({"h_rd_addr ", s}, int'(h_rd_addr[0]), exp_k(c));
      chk({"mac_en ", s},  int'(mac_en[0]), int'(l1_strobe(c - 1) || l2_strobe(c - 1)));
      chk({"mac_clr ", s}, int'(mac_clr[0]),
          int'(wb || c == 23 || c == 28 || c >= 30));
      if (c <= 28) chk({"mac_sel ", s}, int'(mac_sel[0]), int'(c >= 19));
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("h_wr_en%0d %s", g, s), int'(h_wr_en[g]), int'(wb));
         if (wb) begin
            chk($sformatf("h_wr_addr%0d %s", g, s), int'(h_wr_addr[g]), j);
            chk($sformatf("h_wr_data%0d %s", g, s), int'(h_wr_data[g]),
                int'(g == 1 ? v.h8[j] : v.h0[j]));
         end
      end
      if (c == 29) begin
         chk("digit0", int'(digit_out[0]), v.d0);
         chk("digit8", int'(digit_out[1]), v.d8);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit poke_start);
      for (int i = 0; i < N_W; i++)  wrom[i] = int'(v.w[i]);
      for (int i = 0; i < N_IN; i++) xram[i] = int'(v.x[i]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         check_cycle(c, v);
         if (c < 30) begin
            start = poke_start && (c == 5 || c == 20);
            @(posedge clk); #1;
         end
      end
   endtask

   vec_t vecs [NV];

   initial begin
      int o0 [5] = '{-7, 5, 6, 5, -3};
      int o1 [5] = '{-3, 5, 5, 6, 2};
      int dd [5] = '{1, 0, 0, 1, 1};

      for (int i = 0; i < NV; i++) vecs[i] = '0;
      // all-ones weights, image 1..4, no shift: hidden 10s, outputs tie at 30
      for (int i = 0; i < N_W; i++)  vecs[0].w[i] = 32'd1;
      for (int i = 0; i < N_IN; i++) vecs[0].x[i] = 32'(i + 1);
      for (int j = 0; j < N_HID; j++) vecs[0].h0[j] = 8'd10;
      // hidden accumulators -5, 0x10000, 0x300: ReLU, saturate, shift
      vecs[1].x[0]  = 32'd1;
      vecs[1].w[0]  = -32'sd5;
      vecs[1].w[4]  = 32'h0001_0000;
      vecs[1].w[8]  = 32'h0000_0300;
      vecs[1].w[17] = 32'd1;
      vecs[1].h0[1] = 8'd255; vecs[1].h0[2] = 8'd255;
      vecs[1].h8[1] = 8'd255; vecs[1].h8[2] = 8'd3;
      vecs[1].d0 = 1; vecs[1].d8 = 1;
      // hidden {1,0,0} (SHIFT 0) so outputs equal w[12], w[15]
      for (int i = 0; i < 5; i++) begin
         vecs[i + 2].x[0]  = 32'd1;
         vecs[i + 2].w[0]  = 32'd1;
         vecs[i + 2].h0[0] = 8'd1;
         vecs[i + 2].w[12] = 32'(o0[i]);
         vecs[i + 2].w[15] = 32'(o1[i]);
         vecs[i + 2].d0    = dd[i];
      end

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle busy", int'(busy[0]), 0);
      chk("idle mac_clr", int'(mac_clr[0]), 1);
      chk("idle w_rd_en", int'(w_rd_en[0]), 0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], 1'b0);

      // stray starts mid-run, then back-to-back start the cycle after DONE
      run_vec(vecs[0], 1'b1);
      run_vec(vecs[5], 1'b0);

      // asynchronous reset in cycle 8 of L1_RUN
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("pre-reset w_rd_en", int'(w_rd_en[0]), 1);
      chk("pre-reset digit", int'(digit_out[0]), 1);
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("async reset");
      repeat (3) begin
         @(posedge clk); #1;
         chk("in reset valid", int'(valid_out[0]), 0);
         chk("in reset busy", int'(busy[0]), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         chk("post reset valid", int'(valid_out[0]), 0);
      end
      run_vec(vecs[5], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
